// File: rtl/beat_countdown_if.sv
// Beat-countdown command/status bundle.
// The control side (microwave FSM, bench) uses the master modport.
// The timer uses the slave modport.
interface beat_countdown_if;
  logic        beat;
  logic        load;
  logic [15:0] load_bcd;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] time_bcd;
  logic        running;
  logic        paused;
  logic        done;
  logic        load_err;

  modport master (
    output beat, load, load_bcd, start, pause, clear,
    input  time_bcd, running, paused, done, load_err
  );

  modport slave (
    input  beat, load, load_bcd, start, pause, clear,
    output time_bcd, running, paused, done, load_err
  );
endinterface

// File: rtl/beat_countdown.sv
// BCD MM:SS countdown timer clocked by beat enables from a clock divider.
// BEATS_PER_SEC beats make up one second. When a decrement reaches 00:00,
// the timer pulses done for one cycle and then holds in DONE.
// Optional build macro BEAT_COUNTDOWN_SATURATE_EN:
//   - defined: out-of-range load digits are clamped and load_err stays 0.
//   - undefined: an out-of-range load is rejected and load_err pulses.
module beat_countdown #(
  parameter int unsigned BEATS_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             reset,
  beat_countdown_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] SubLast = 16'(BEATS_PER_SEC - 1);

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [15:0] sub_q, sub_d;
  logic        running_q, running_d;
  logic        paused_q, paused_d;
  logic        done_q, done_d;
  logic        load_err_q, load_err_d;
  logic [15:0] dec_time;

  // One-second BCD decrement with borrow through all four digits.
  function automatic logic [15:0] dec_bcd(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          if (mt != 4'd0) mt = mt - 4'd1;
          else            mt = 4'd9;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

`ifdef BEAT_COUNTDOWN_SATURATE_EN
  // Clamp each digit into its legal range.
  function automatic logic [15:0] sat_bcd(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (mt > 4'd9) mt = 4'd9;
    if (mo > 4'd9) mo = 4'd9;
    if (st > 4'd5) st = 4'd5;
    if (so > 4'd9) so = 4'd9;
    return {mt, mo, st, so};
  endfunction
`else
  // A load is valid only when every digit is legal for its position.
  function automatic logic bcd_valid(input logic [15:0] t);
    return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
  endfunction
`endif

  // Next-state: clear > load > start/pause > beat, with flags derived from the next state.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    sub_d      = sub_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    dec_time   = dec_bcd(time_q);

    if (bus.clear) begin
      state_d = S_IDLE;
      time_d  = 16'h0000;
      sub_d   = 16'h0000;
    end else if (bus.load && (state_q != S_RUN)) begin
`ifdef BEAT_COUNTDOWN_SATURATE_EN
      state_d = S_IDLE;
      time_d  = sat_bcd(bus.load_bcd);
      sub_d   = 16'h0000;
`else
      if (bcd_valid(bus.load_bcd)) begin
        state_d = S_IDLE;
        time_d  = bus.load_bcd;
        sub_d   = 16'h0000;
      end else begin
        load_err_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          // pause wins over start; a zero time cannot be started.
          if (bus.start && !bus.pause && (time_q != 16'h0000)) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (bus.beat) begin
            if (sub_q == SubLast) begin
              sub_d  = 16'h0000;
              time_d = dec_time;
              if (dec_time == 16'h0000) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end else begin
              sub_d = sub_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == S_RUN);
    paused_d  = (state_d == S_PAUSE);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      time_q     <= 16'h0000;
      sub_q      <= 16'h0000;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      sub_q      <= sub_d;
      running_q  <= running_d;
      paused_q   <= paused_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.time_bcd = time_q;
  assign bus.running  = running_q;
  assign bus.paused   = paused_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_beat_countdown.sv
// Bench for beat_countdown.
// Two instances share the same stimulus: one with BEATS_PER_SEC=1 and one with BEATS_PER_SEC=4.
// Each step checks only the selected instance.
module tb_beat_countdown;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  beat_countdown_if if1();
  beat_countdown_if if4();

  beat_countdown #(.BEATS_PER_SEC(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(if1));
  beat_countdown #(.BEATS_PER_SEC(4)) u_dut4 (.clk(clk), .reset(rst_n), .bus(if4));

  typedef struct {
    logic        beat, load;
    logic [15:0] bcd;
    logic        start, pause, clear;
    logic [15:0] t;
    logic        run, pau, done, err;
  } vec_t;

  typedef struct {
    int          sel;
    logic [15:0] t;
    logic        run, pau, done, err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t V(input logic b, input logic l, input logic [15:0] bcd,
                             input logic s, input logic p, input logic c,
                             input logic [15:0] t, input logic r, input logic pa,
                             input logic d, input logic e);
    vec_t v;
    v.beat = b; v.load = l; v.bcd = bcd; v.start = s; v.pause = p; v.clear = c;
    v.t = t; v.run = r; v.pau = pa; v.done = d; v.err = e;
    return v;
  endfunction

  task automatic cmp(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, required %h", name, field, act, req);
    end
  endtask

  task automatic check_one();
    exp_t        x;
    logic [15:0] at;
    logic        ar, ap, ad, ae;
    x = sb.pop_front();
    if (x.sel == 4) begin
      at = if4.time_bcd; ar = if4.running; ap = if4.paused; ad = if4.done; ae = if4.load_err;
    end else begin
      at = if1.time_bcd; ar = if1.running; ap = if1.paused; ad = if1.done; ae = if1.load_err;
    end
    cmp(x.name, "time_bcd", at, x.t);
    cmp(x.name, "running", {15'd0, ar}, {15'd0, x.run});
    cmp(x.name, "paused", {15'd0, ap}, {15'd0, x.pau});
    cmp(x.name, "done", {15'd0, ad}, {15'd0, x.done});
    cmp(x.name, "load_err", {15'd0, ae}, {15'd0, x.err});
  endtask

  // Drive one cycle of stimulus into both instances, queue the expectation, and check after the edge.
  task automatic step(input int sel, input logic rn, input vec_t v, input string name);
    exp_t e;
    rst_n = rn;
    if1.beat = v.beat; if1.load = v.load; if1.load_bcd = v.bcd;
    if1.start = v.start; if1.pause = v.pause; if1.clear = v.clear;
    if4.beat = v.beat; if4.load = v.load; if4.load_bcd = v.bcd;
    if4.start = v.start; if4.pause = v.pause; if4.clear = v.clear;
    e.sel = sel; e.t = v.t; e.run = v.run; e.pau = v.pau; e.done = v.done; e.err = v.err;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  vec_t tbl[$];
  vec_t r;

  initial begin
    rst_n = 1'b0;
    if1.beat = 0; if1.load = 0; if1.load_bcd = 0; if1.start = 0; if1.pause = 0; if1.clear = 0;
    if4.beat = 0; if4.load = 0; if4.load_bcd = 0; if4.start = 0; if4.pause = 0; if4.clear = 0;

    // Hold reset for three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      r = V($urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            16'h0000, 0, 0, 0, 0);
      step((i == 1) ? 4 : 1, 1'b0, r, $sformatf("reset%0d", i));
    end

    // Vector table for the BEATS_PER_SEC=1 instance.
    //              beat load bcd       st ps cl  time     run pau done err
    tbl.push_back(V(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0)); // start at 0 ignored
    tbl.push_back(V(0, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0, 0)); // load 00:03
    tbl.push_back(V(1, 0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0, 0, 0)); // start; beat not counted
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, 0, 0));
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, 0, 0)); // no beat: hold
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0)); // terminal count
    tbl.push_back(V(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0)); // done one cycle only
    tbl.push_back(V(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0)); // start in DONE ignored
    tbl.push_back(V(0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 0)); // load in DONE
    tbl.push_back(V(0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0, 0));
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0959, 1, 0, 0, 0)); // 10:00 -> 09:59
    tbl.push_back(V(0, 1, 16'h0100, 0, 0, 0, 16'h0959, 1, 0, 0, 0)); // load in RUN ignored
    tbl.push_back(V(0, 0, 16'h0000, 1, 1, 0, 16'h0959, 0, 1, 0, 0)); // start+pause -> PAUSE
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0959, 0, 1, 0, 0)); // beat in PAUSE ignored
    tbl.push_back(V(0, 0, 16'h0000, 1, 0, 0, 16'h0959, 1, 0, 0, 0)); // resume
    tbl.push_back(V(0, 0, 16'h0000, 0, 1, 0, 16'h0959, 0, 1, 0, 0));
    tbl.push_back(V(0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0, 0)); // load in PAUSE
    tbl.push_back(V(0, 0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0, 0, 0));
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0059, 1, 0, 0, 0)); // 01:00 -> 00:59
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0058, 1, 0, 0, 0));
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 0)); // clear from RUN
    tbl.push_back(V(0, 1, 16'h0042, 0, 0, 0, 16'h0042, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 16'h0003, 0, 0, 1, 16'h0000, 0, 0, 0, 0)); // clear beats load
`ifdef BEAT_COUNTDOWN_SATURATE_EN
    tbl.push_back(V(0, 1, 16'h0A7B, 0, 0, 0, 16'h0959, 0, 0, 0, 0)); // clamped load
    tbl.push_back(V(0, 0, 16'h0000, 0, 0, 0, 16'h0959, 0, 0, 0, 0));
`else
    tbl.push_back(V(0, 1, 16'h0A7B, 0, 0, 0, 16'h0000, 0, 0, 0, 1)); // rejected load
    tbl.push_back(V(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0)); // err one cycle only
`endif
    tbl.push_back(V(0, 1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 16'h0000, 1, 0, 0, 16'h0005, 1, 0, 0, 0));
    tbl.push_back(V(1, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 0, 0, 0));

    foreach (tbl[i]) step(1, 1'b1, tbl[i], $sformatf("vec%0d", i));

    // Reset mid-count wins over an active beat.
    step(1, 1'b0, V(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0), "midreset");
    step(1, 1'b1, V(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0), "postreset");

    // Prescale with pause on the BEATS_PER_SEC=4 instance.
    step(4, 1'b1, V(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 0), "ps_clear");
    step(4, 1'b1, V(0, 1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0, 0), "ps_load");
    step(4, 1'b1, V(0, 0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0, 0), "ps_start");
    for (int i = 0; i < 2; i++)
      step(4, 1'b1, V(1, 0, 16'h0000, 0, 0, 0, 16'h0010, 1, 0, 0, 0), $sformatf("ps_beat%0d", i));
    step(4, 1'b1, V(0, 0, 16'h0000, 0, 1, 0, 16'h0010, 0, 1, 0, 0), "ps_pause");
    for (int i = 0; i < 5; i++)
      step(4, 1'b1, V(1, 0, 16'h0000, 0, 0, 0, 16'h0010, 0, 1, 0, 0), $sformatf("ps_pbeat%0d", i));
    step(4, 1'b1, V(0, 0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0, 0), "ps_resume");
    step(4, 1'b1, V(1, 0, 16'h0000, 0, 0, 0, 16'h0010, 1, 0, 0, 0), "ps_rbeat0");
    step(4, 1'b1, V(1, 0, 16'h0000, 0, 0, 0, 16'h0009, 1, 0, 0, 0), "ps_rbeat1");
    for (int i = 0; i < 3; i++)
      step(4, 1'b1, V(1, 0, 16'h0000, 0, 0, 0, 16'h0009, 1, 0, 0, 0), $sformatf("ps_full%0d", i));
    step(4, 1'b1, V(1, 0, 16'h0000, 0, 0, 0, 16'h0008, 1, 0, 0, 0), "ps_full3");

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
